// File: rtl/apple_video_prefetch_if.sv
// SDRAM video client port of the Apple II shadow-memory read engine.
// The prefetch engine is the master: it issues word reads and receives
// in-order read data.
interface apple_video_prefetch_if;
    logic        mem_rd_o;     // read request, held until accepted
    logic [20:0] mem_addr_o;   // {5'b0, bank, word address[14:0]}
    logic        mem_ready_i;  // request accepted this cycle
    logic        mem_valid_i;  // read data valid, in request order
    logic [31:0] mem_q_i;      // read data, four byte lanes

    modport master (
        output mem_rd_o,
        output mem_addr_o,
        input  mem_ready_i,
        input  mem_valid_i,
        input  mem_q_i
    );

    modport slave (
        input  mem_rd_o,
        input  mem_addr_o,
        output mem_ready_i,
        output mem_valid_i,
        output mem_q_i
    );
endinterface

// File: rtl/apple_video_prefetch.sv
// Apple II video line prefetch: bursts one scanline of 32-bit shadow words
// from the SDRAM video port into a ping-pong line buffer, while scanout
// reads single main/aux bytes from the front buffer with one cycle latency.
// Optional fetch statistics outputs: define VIDEO_PREFETCH_STATS_EN.
module apple_video_prefetch #(
    parameter int WORDS_PER_LINE  = 20,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                   clk_logic,
    input  logic                   system_reset_n,
    input  logic                   line_start_i,
    input  logic [15:0]            line_base_i,
    input  logic                   line_bank_i,
    output logic                   busy_o,
    output logic                   line_done_o,
    output logic                   overrun_o,
    apple_video_prefetch_if.master mem,
    input  logic [6:0]             pix_addr_i,
    input  logic                   pix_aux_i,
    output logic [7:0]             pix_data_o
`ifdef VIDEO_PREFETCH_STATS_EN
    ,
    output logic [15:0]            last_fetch_cycles_o,
    output logic [3:0]             max_outstanding_o
`endif
);
    localparam logic [6:0] LINE_WORDS = 7'(WORDS_PER_LINE);
    localparam logic [7:0] LINE_BYTES = 8'(2 * WORDS_PER_LINE);
    localparam logic [3:0] MAX_OUT    = 4'(MAX_OUTSTANDING);
    // Buffer index width sized exactly to the line length.
    localparam int IW = (WORDS_PER_LINE > 1) ? $clog2(WORDS_PER_LINE) : 1;

    typedef enum logic [1:0] {IDLE, REQ, DRAIN, SWAP} state_t;

    state_t      state, state_next;
    logic [14:0] word_base;
    logic        bank;
    logic [6:0]  req_cnt;
    logic [6:0]  rsp_cnt;
    logic [3:0]  outstanding;
    logic        front_sel;
    logic [31:0] line_buf [2][WORDS_PER_LINE];
    logic [31:0] front_word;

    logic start_ok;
    logic accept;
    logic rsp_ok;
    logic unused_base_lsb;

    // Line base is always even; its LSB carries no information.
    assign unused_base_lsb = line_base_i[0];

    assign start_ok = line_start_i && (state == IDLE);
    assign accept   = mem.mem_rd_o && mem.mem_ready_i;
    // Responses only count during a fetch and only against a request in flight.
    assign rsp_ok   = mem.mem_valid_i && ((state == REQ) || (state == DRAIN))
                      && (outstanding != 4'd0) && (rsp_cnt < LINE_WORDS);

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk_logic or negedge system_reset_n) begin
        if (!system_reset_n) state <= IDLE;
        else                 state <= state_next;
    end

    // Next-state decode.
    // NOTE: default assignment first so no path leaves state_next unassigned
    // (which would infer a latch).
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (line_start_i) state_next = REQ;
            REQ:     if (accept && (req_cnt == LINE_WORDS - 7'd1)) state_next = DRAIN;
            DRAIN:   if (rsp_cnt == LINE_WORDS) state_next = SWAP;
            SWAP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs decoded from state and request/response counters.
    always_comb begin
        busy_o         = (state != IDLE);
        line_done_o    = (state == SWAP);
        mem.mem_rd_o   = (state == REQ) && (req_cnt < LINE_WORDS)
                         && (outstanding < MAX_OUT);
        mem.mem_addr_o = {5'b0, bank, word_base + {8'b0, req_cnt}};
    end

    // Fetch bookkeeping: latched line base, counters, front select, overrun.
    always_ff @(posedge clk_logic or negedge system_reset_n) begin
        if (!system_reset_n) begin
            word_base   <= '0;
            bank        <= 1'b0;
            req_cnt     <= '0;
            rsp_cnt     <= '0;
            outstanding <= '0;
            front_sel   <= 1'b0;
            overrun_o   <= 1'b0;
        end else begin
            if (line_start_i && (state != IDLE)) overrun_o <= 1'b1;
            if (start_ok) begin
                word_base   <= line_base_i[15:1];
                bank        <= line_bank_i;
                req_cnt     <= '0;
                rsp_cnt     <= '0;
                outstanding <= '0;
            end else begin
                if (accept) req_cnt <= req_cnt + 7'd1;
                if (rsp_ok) rsp_cnt <= rsp_cnt + 7'd1;
                if (accept && !rsp_ok)      outstanding <= outstanding + 4'd1;
                else if (!accept && rsp_ok) outstanding <= outstanding - 4'd1;
            end
            if (state == SWAP) front_sel <= ~front_sel;
        end
    end

    // Response capture into the back buffer.
    // NOTE: the line buffers are RAM and deliberately have no reset; their
    // contents are don't-care until a fetch completes.
    always_ff @(posedge clk_logic) begin
        if (rsp_ok) line_buf[~front_sel][rsp_cnt[IW-1:0]] <= mem.mem_q_i;
    end

    assign front_word = line_buf[front_sel][pix_addr_i[IW:1]];

    // Registered scanout byte; lane = {odd byte, aux}. Beyond the line reads 0.
    always_ff @(posedge clk_logic or negedge system_reset_n) begin
        if (!system_reset_n) begin
            pix_data_o <= 8'h00;
        end else if ({1'b0, pix_addr_i} >= LINE_BYTES) begin
            pix_data_o <= 8'h00;
        end else begin
            case ({pix_addr_i[0], pix_aux_i})
                2'd0:    pix_data_o <= front_word[7:0];
                2'd1:    pix_data_o <= front_word[15:8];
                2'd2:    pix_data_o <= front_word[23:16];
                default: pix_data_o <= front_word[31:24];
            endcase
        end
    end

`ifdef VIDEO_PREFETCH_STATS_EN
    logic [15:0] fetch_cycles;

    // Fetch duration (start acceptance to line_done, saturating) and peak
    // outstanding reads since reset.
    always_ff @(posedge clk_logic or negedge system_reset_n) begin
        if (!system_reset_n) begin
            fetch_cycles        <= '0;
            last_fetch_cycles_o <= '0;
            max_outstanding_o   <= '0;
        end else begin
            if (start_ok)
                fetch_cycles <= 16'd1;
            else if (busy_o && (fetch_cycles != 16'hFFFF))
                fetch_cycles <= fetch_cycles + 16'd1;
            if (state == SWAP) last_fetch_cycles_o <= fetch_cycles;
            if (outstanding > max_outstanding_o) max_outstanding_o <= outstanding;
        end
    end
`endif
endmodule
